// File: rtl/arith_pkg.sv
// Shared mode encodings and saturation-constant helpers for the arith accumulator.
package arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } sat_mode_e;

    // Constants are built 32 bits wide; callers keep the low w bits.
    function automatic logic [31:0] sat_max(input int w);
        return (32'h1 << (w - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return 32'h1 << (w - 1);
    endfunction

endpackage

// File: rtl/arith_core.sv
// Combinational two's-complement add/subtract with signed overflow detection.
module arith_core #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic                    SUB,
    output logic signed [WIDTH-1:0] SUM,
    output logic                    OV
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] raw;

    // Subtraction is A + ~B + 1, so the carry-in is SUB itself.
    assign b_eff = SUB ? ~B : B;
    assign raw   = A + b_eff + {{(WIDTH-1){1'b0}}, SUB};
    assign SUM   = raw;
    assign OV    = (A[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/arith_acc.sv
// Registered add/sub/accumulate unit with optional saturation and overflow statistics.
module arith_acc
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_vld,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic                    SUB,
    input  logic                    ACC,
    input  logic                    SAT,
    output logic signed [WIDTH-1:0] SUM,
    output logic                    OV,
    output logic                    out_vld,
    output logic                    OV_STICKY,
    output logic [CNT_W-1:0]        OV_CNT
);

    localparam logic [31:0] MAX32 = sat_max(WIDTH);
    localparam logic [31:0] MIN32 = sat_min(WIDTH);

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic ov,
                                                  input logic a_neg,
                                                  input sat_mode_e mode);
        if (ov && mode == MODE_SAT)
            return a_neg ? MIN32[WIDTH-1:0] : MAX32[WIDTH-1:0];
        return raw;
    endfunction

    logic signed [WIDTH-1:0] sum_q, sum_d;
    logic                    ov_q, ov_d;
    logic                    vld_q, vld_d;
    logic                    sticky_q, sticky_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic signed [WIDTH-1:0] op_a;
    logic signed [WIDTH-1:0] core_sum;
    logic                    core_ov;
    op_e                     op;
    sat_mode_e               mode;

    assign op   = op_e'(SUB);
    assign mode = sat_mode_e'(SAT);
    // Accumulate mode feeds back the registered result of the previous op.
    assign op_a = ACC ? sum_q : A;

    arith_core #(.WIDTH(WIDTH)) u_core (
        .A  (op_a),
        .B  (B),
        .SUB(op == OP_SUB),
        .SUM(core_sum),
        .OV (core_ov)
    );

    always_comb begin
        sum_d    = sum_q;
        ov_d     = ov_q;
        vld_d    = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr) begin
            sum_d    = '0;
            ov_d     = 1'b0;
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (in_vld) begin
            sum_d    = saturate(core_sum, core_ov, op_a[WIDTH-1], mode);
            ov_d     = core_ov;
            vld_d    = 1'b1;
            sticky_d = sticky_q | core_ov;
            if (core_ov && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end
    end

    // Result stage: one clock from acceptance to SUM/OV/out_vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            ov_q     <= 1'b0;
            vld_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sum_q    <= sum_d;
            ov_q     <= ov_d;
            vld_q    <= vld_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign SUM       = sum_q;
    assign OV        = ov_q;
    assign out_vld   = vld_q;
    assign OV_STICKY = sticky_q;
    assign OV_CNT    = cnt_q;

endmodule

// File: tb/tb_arith_acc.sv
// Bench for arith_acc (WIDTH=8, CNT_W=4): fixed vectors, corner sequences, random ops vs model.
module tb_arith_acc;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_vld = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          SUB = 1'b0;
    logic          ACC = 1'b0;
    logic          SAT = 1'b0;
    logic [W-1:0]  SUM;
    logic          OV;
    logic          out_vld;
    logic          OV_STICKY;
    logic [CW-1:0] OV_CNT;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state, computed with plain integer arithmetic.
    int m_sum, m_ov, m_vld, m_sticky, m_cnt;

    arith_acc #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld),
        .A(A), .B(B), .SUB(SUB), .ACC(ACC), .SAT(SAT),
        .SUM(SUM), .OV(OV), .out_vld(out_vld),
        .OV_STICKY(OV_STICKY), .OV_CNT(OV_CNT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sum = 0; m_ov = 0; m_vld = 0; m_sticky = 0; m_cnt = 0;
    endtask

    task automatic model_op(input bit v, input bit c, input bit acc, input bit sub,
                            input bit sat, input int a, input int b);
        int ai, bi, r, ovf;
        if (c) begin
            model_reset();
        end else if (v) begin
            ai  = acc ? m_sum : a;
            ai  = (ai >= 128) ? ai - 256 : ai;
            bi  = (b  >= 128) ? b  - 256 : b;
            r   = sub ? ai - bi : ai + bi;
            ovf = (r > 127 || r < -128) ? 1 : 0;
            if (ovf && sat) m_sum = (ai < 0) ? 8'h80 : 8'h7F;
            else            m_sum = r & 8'hFF;
            m_ov     = ovf;
            m_vld    = 1;
            m_sticky = m_sticky | ovf;
            m_cnt    = (m_cnt + ovf > 15) ? 15 : m_cnt + ovf;
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".SUM"},       int'(SUM),       m_sum);
        chk({tag, ".OV"},        int'(OV),        m_ov);
        chk({tag, ".out_vld"},   int'(out_vld),   m_vld);
        chk({tag, ".OV_STICKY"}, int'(OV_STICKY), m_sticky);
        chk({tag, ".OV_CNT"},    int'(OV_CNT),    m_cnt);
    endtask

    // Drive one cycle, clock it, then compare every output against the model.
    task automatic step(input string tag, input bit v, input bit c, input bit acc,
                        input bit sub, input bit sat, input logic [7:0] a, input logic [7:0] b);
        in_vld = v; clr = c; ACC = acc; SUB = sub; SAT = sat; A = a; B = b;
        model_op(v, c, acc, sub, sat, int'(a), int'(b));
        @(posedge clk);
        #1;
        in_vld = 1'b0; clr = 1'b0;
        check_all(tag);
    endtask

    typedef struct {
        logic [7:0] a, b;
        bit         sub, sat;
        logic [7:0] exp_sum;
        bit         exp_ov;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b1};
        vecs[1] = '{8'h7F, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1};
        vecs[2] = '{8'h80, 8'h07, 1'b1, 1'b0, 8'h79, 1'b1};
        vecs[3] = '{8'h80, 8'h07, 1'b1, 1'b1, 8'h80, 1'b1};
        vecs[4] = '{8'hCC, 8'h22, 1'b1, 1'b0, 8'hAA, 1'b0};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0};
        vecs[6] = '{8'hFF, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b0};
        vecs[7] = '{8'h00, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1};
        vecs[8] = '{8'h00, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b1};
        vecs[9] = '{8'h80, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1};

        model_reset();

        // Reset state, and an op held across an edge while in reset is dropped.
        #3;
        check_all("reset");
        in_vld = 1'b1; A = 8'h11; B = 8'h22;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        rst = 1'b0;
        check_all("op_in_reset");

        // First table vector after reset: sticky/count visible one cycle later.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), 1'b1, 1'b0, 1'b0, vecs[i].sub, vecs[i].sat,
                 vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d.sum_tbl", i), int'(SUM), int'(vecs[i].exp_sum));
            chk($sformatf("vec%0d.ov_tbl", i),  int'(OV),  int'(vecs[i].exp_ov));
            if (i == 0) begin
                chk("vec0.sticky_tbl", int'(OV_STICKY), 1);
                chk("vec0.cnt_tbl",    int'(OV_CNT),    1);
            end
        end

        // Idle cycle: hold results, no valid pulse.
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8'h55);

        // Saturating accumulation from a cleared state.
        step("clr_a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step("acc1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h40);
        chk("acc1.sum_c", int'(SUM), 8'h40);
        step("acc2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h40);
        chk("acc2.sum_c", int'(SUM), 8'h7F);
        chk("acc2.ov_c",  int'(OV),  1);
        step("acc3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h40);
        chk("acc3.sum_c", int'(SUM), 8'h7F);
        chk("acc3.cnt_c", int'(OV_CNT), 2);

        // Counter saturation, then clr wins over a simultaneous op.
        for (int i = 0; i < 20; i++)
            step($sformatf("ovrun%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h7F);
        chk("ovrun.cnt_c", int'(OV_CNT), 15);
        step("clr_vld", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01);
        chk("clr_vld.sum_c", int'(SUM), 0);
        chk("clr_vld.vld_c", int'(out_vld), 0);
        chk("clr_vld.cnt_c", int'(OV_CNT), 0);

        // Asynchronous reset mid-accumulation loses the running sum.
        step("racc1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10);
        step("racc2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10);
        chk("racc2.sum_c", int'(SUM), 8'h20);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.sum_c", int'(SUM), 0);
        #1;
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h05);
        chk("post_rst.sum_c", int'(SUM), 8'h05);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
